// File: rtl/xor_parity_accum_if.sv
// Packet-beat bus for the XOR parity accumulator: the source drives beats, the checker returns results.
interface xor_parity_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_first;
    logic             in_last;
    logic             in_exp;

    logic             out_valid;
    logic             out_par;
    logic             out_err;
    logic [CNT_W-1:0] out_beats;
    logic             proto_err;

    modport master (
        output in_valid, in_data, in_first, in_last, in_exp,
        input  out_valid, out_par, out_err, out_beats, proto_err
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, in_exp,
        output out_valid, out_par, out_err, out_beats, proto_err
    );
endinterface

// File: rtl/xor_parity_accum.sv
// Multi-beat packet parity generator/checker: XOR-reduces every bit of a first..last framed packet
// and flags a mismatch against the expected parity carried on the last beat.
module xor_parity_accum #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0,
    parameter bit PIPE  = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    xor_parity_accum_if.slave bus
);
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int LEAVES = 1 << LEVELS;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Balanced reduction tree; leaves beyond WIDTH are tied to 0 so odd widths stay balanced.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [(LEAVES >> l)-1:0] v;
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < LEAVES; i++) begin : g_bit
                if (i < WIDTH) begin : g_data
                    assign v[i] = bus.in_data[i];
                end else begin : g_pad
                    assign v[i] = 1'b0;
                end
            end
        end else begin : g_node
            for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_bit
                assign v[i] = g_lvl[l-1].v[2*i] ^ g_lvl[l-1].v[2*i+1];
            end
        end
    end

    logic beat_par;
    assign beat_par = g_lvl[LEVELS].v[0];

    logic s_valid;
    logic s_first;
    logic s_last;
    logic s_exp;
    logic s_bp;

    if (PIPE) begin : g_pipe
        logic valid_q;
        logic first_q;
        logic last_q;
        logic exp_q;
        logic bp_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                exp_q   <= 1'b0;
                bp_q    <= 1'b0;
            end else begin
                valid_q <= bus.in_valid;
                first_q <= bus.in_first;
                last_q  <= bus.in_last;
                exp_q   <= bus.in_exp;
                bp_q    <= beat_par;
            end
        end

        assign s_valid = valid_q;
        assign s_first = first_q;
        assign s_last  = last_q;
        assign s_exp   = exp_q;
        assign s_bp    = bp_q;
    end else begin : g_direct
        assign s_valid = bus.in_valid;
        assign s_first = bus.in_first;
        assign s_last  = bus.in_last;
        assign s_exp   = bus.in_exp;
        assign s_bp    = beat_par;
    end

    state_t           state_q;
    logic             acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic             out_par_q;
    logic             out_err_q;
    logic [CNT_W-1:0] out_beats_q;
    logic             proto_err_q;

    logic             cnt_inc_d;
    logic [CNT_W-1:0] cnt_sat_d;
    logic             fin_par_d;
    logic [CNT_W-1:0] fin_cnt_d;

    // The count pins at all-ones; parity keeps accumulating regardless.
    assign cnt_inc_d = ~(&cnt_q);
    assign cnt_sat_d = cnt_inc_d ? cnt_q + CNT_W'(1) : cnt_q;

    // A first beat always restarts the packet, whatever state the FSM was in.
    assign fin_par_d = (s_first ? s_bp : (acc_q ^ s_bp)) ^ ODD;
    assign fin_cnt_d = s_first ? CNT_W'(1) : cnt_sat_d;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_beats_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            if (s_valid) begin
                if (s_first || (state_q == BUSY)) begin
                    if (s_first && (state_q == BUSY)) begin
                        proto_err_q <= 1'b1;
                    end
                    if (s_last) begin
                        out_valid_q <= 1'b1;
                        out_par_q   <= fin_par_d;
                        out_err_q   <= fin_par_d ^ s_exp;
                        out_beats_q <= fin_cnt_d;
                        state_q     <= IDLE;
                    end else begin
                        acc_q   <= s_first ? s_bp : (acc_q ^ s_bp);
                        cnt_q   <= fin_cnt_d;
                        state_q <= BUSY;
                    end
                end else begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_par   = out_par_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_beats = out_beats_q;
    assign bus.proto_err = proto_err_q;
endmodule
